// File: rtl/alu_op_decoder.sv
// alu_op_decoder: turns a RISC-V instruction word into ALU control fields.
// The outputs come from a register. A second holding entry catches the
// instruction accepted in the same cycle that the execute stage stalls.
module alu_op_decoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      ALUControl,
    output logic            isSLT,
    output logic            isU,
    output logic            SrcBImm,
    output logic            illegal
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_LSL = 3'b101;
    localparam logic [2:0] ALU_LSR = 3'b110;
    localparam logic [2:0] ALU_ASR = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Each entry is stored as {illegal, SrcBImm, isU, isSLT, ALUControl}.
    logic [6:0] dec_word;
    logic [6:0] out_word;
    logic [6:0] skid_word;
    logic       skid_full;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [2:0] dec_alu;
    logic       dec_slt;
    logic       dec_u;
    logic       dec_imm;
    logic       dec_ill;
    logic       accept;
    logic       retire;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    // Decode the incoming instruction into its ALU control fields.
    always_comb begin
        dec_alu = ALU_ADD;
        dec_slt = 1'b0;
        dec_u   = 1'b0;
        dec_imm = 1'b0;
        dec_ill = 1'b0;
        unique case (opcode)
            7'b0110011: begin
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'b000: dec_alu = ALU_ADD;
                        3'b001: dec_alu = ALU_LSL;
                        3'b010: dec_slt = 1'b1;
                        3'b011: begin dec_slt = 1'b1; dec_u = 1'b1; end
                        3'b100: dec_alu = ALU_XOR;
                        3'b101: dec_alu = ALU_LSR;
                        3'b110: dec_alu = ALU_OR;
                        default: dec_alu = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_alu = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_alu = ALU_ASR;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0010011: begin
                dec_imm = 1'b1;
                unique case (funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b001: begin
                        if (funct7 == F7_BASE) dec_alu = ALU_LSL;
                        else                   dec_ill = 1'b1;
                    end
                    3'b010: dec_slt = 1'b1;
                    3'b011: begin dec_slt = 1'b1; dec_u = 1'b1; end
                    3'b100: dec_alu = ALU_XOR;
                    3'b101: begin
                        if (funct7 == F7_BASE)     dec_alu = ALU_LSR;
                        else if (funct7 == F7_ALT) dec_alu = ALU_ASR;
                        else                       dec_ill = 1'b1;
                    end
                    3'b110: dec_alu = ALU_OR;
                    default: dec_alu = ALU_AND;
                endcase
            end
            7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111: begin
                dec_imm = 1'b1;
            end
            7'b1100111: begin
                if (funct3 == 3'b000) dec_imm = 1'b1;
                else                  dec_ill = 1'b1;
            end
            7'b1100011: begin
                unique case (funct3)
                    3'b000, 3'b001: dec_alu = ALU_SUB;
                    3'b100, 3'b101: dec_slt = 1'b1;
                    3'b110, 3'b111: begin dec_slt = 1'b1; dec_u = 1'b1; end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal entries carry no control information beyond the flag.
        if (dec_ill) dec_word = 7'b1000000;
        else         dec_word = {1'b0, dec_imm, dec_u, dec_slt, dec_alu};
    end

    // Output register and skid entry; flush wins over accept and retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            skid_full <= 1'b0;
            skid_word <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            skid_full <= 1'b0;
        end else if (!out_valid || retire) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                out_word  <= skid_word;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_word  <= dec_word;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
            skid_word <= dec_word;
        end
    end

    // Present the held entry; in_ready comes straight from the skid flop.
    always_comb begin
        in_ready   = ~skid_full;
        ALUControl = out_word[2:0];
        isSLT      = out_word[3];
        isU        = out_word[4];
        SrcBImm    = out_word[5];
        illegal    = out_word[6];
    end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder with hand-computed expectations.
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  ALUControl;
    logic        isSLT;
    logic        isU;
    logic        SrcBImm;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_decoder #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUControl (ALUControl),
        .isSLT      (isSLT),
        .isU        (isU),
        .SrcBImm    (SrcBImm),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the full output bundle {out_valid, illegal, SrcBImm, isU, isSLT, ALUControl}.
    task automatic chk_out(input string tag, input logic v, input logic ill, input logic imm,
                           input logic u, input logic slt, input logic [2:0] alu);
        chk(tag, {24'd0, out_valid, illegal, SrcBImm, isU, isSLT, ALUControl},
                 {24'd0, v, ill, imm, u, slt, alu});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        step();
        chk_out("reset_outputs", 0, 0, 0, 0, 0, 3'b000);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        reset = 1'b0;
        step();
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // back-to-back with the consumer always ready
        out_ready = 1'b1; in_valid = 1'b1;
        instr = 32'h003100B3; step();
        chk_out("add", 1, 0, 0, 0, 0, 3'b000);
        instr = 32'h403100B3; step();
        chk_out("sub", 1, 0, 0, 0, 0, 3'b001);
        instr = 32'h40315093; step();
        chk_out("srai", 1, 0, 1, 0, 0, 3'b111);
        in_valid = 1'b0; step();
        chk("drained_valid", {31'd0, out_valid}, 32'd0);

        // backpressure fills the skid entry
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h0020E0B3; step();
        chk_out("or_first", 1, 0, 0, 0, 0, 3'b011);
        chk("or_in_ready", {31'd0, in_ready}, 32'd1);
        instr = 32'h0020F0B3; step();
        chk_out("or_held", 1, 0, 0, 0, 0, 3'b011);
        chk("skid_full_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; step();
        chk_out("or_still_held", 1, 0, 0, 0, 0, 3'b011);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1; step();
        chk_out("and_from_skid", 1, 0, 0, 0, 0, 3'b010);
        chk("skid_drained_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // branches, compares and immediate-only opcodes
        in_valid = 1'b1;
        instr = 32'h0020E463; step();
        chk_out("bltu", 1, 0, 0, 1, 1, 3'b000);
        instr = 32'h00208463; step();
        chk_out("beq", 1, 0, 0, 0, 0, 3'b001);
        instr = 32'h0020A0B3; step();
        chk_out("slt", 1, 0, 0, 0, 1, 3'b000);
        instr = 32'h0020C0B3; step();
        chk_out("xor", 1, 0, 0, 0, 0, 3'b100);
        instr = 32'h000010B7; step();
        chk_out("lui", 1, 0, 1, 0, 0, 3'b000);
        instr = 32'h0020A463; step();
        chk_out("branch_f3_010_illegal", 1, 1, 0, 0, 0, 3'b000);

        // illegal words pass through, then decoding recovers
        instr = 32'h00000000; step();
        chk_out("zero_illegal", 1, 1, 0, 0, 0, 3'b000);
        instr = 32'h023100B3; step();
        chk_out("mul_illegal", 1, 1, 0, 0, 0, 3'b000);
        instr = 32'h40311093; step();
        chk_out("slli_alt_illegal", 1, 1, 0, 0, 0, 3'b000);
        instr = 32'h00310093; step();
        chk_out("addi", 1, 0, 1, 0, 0, 3'b000);
        in_valid = 1'b0; step();

        // flush with both entries full and a new instruction offered
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h0020C0B3; step();
        instr = 32'h0020E0B3; step();
        chk("flush_pre_full", {30'd0, out_valid, in_ready}, 32'b10);
        flush = 1'b1; instr = 32'h0020F0B3; step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        // flush while ready: the offered instruction is dropped
        instr = 32'h003100B3; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        chk("no_flushed_entry_1", {31'd0, out_valid}, 32'd0);
        step();
        chk("no_flushed_entry_2", {31'd0, out_valid}, 32'd0);

        // asynchronous reset mid-stream with both entries full
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h0020C0B3; step();
        instr = 32'h403100B3; step();
        chk("reset_pre_full", {30'd0, out_valid, in_ready}, 32'b10);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk_out("async_reset_outputs", 0, 0, 0, 0, 0, 3'b000);
        step();
        reset = 1'b0;
        step();
        chk("reset_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_release_valid", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
